// File: rtl/keypad_pkg.sv
// keypad_pkg: shared matrix geometry, key indexing and popcount for the keypad scanner
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  // Key index is row*4 + col, which is simply the row and column numbers concatenated
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the debounced key outputs
interface keypad_scanner_if;
  import keypad_pkg::*;
  logic [NUM_COLS-1:0] cols;
  logic [NUM_ROWS-1:0] rows;
  logic [NUM_KEYS-1:0] pad;
  logic multi_press;
  logic new_press;
  modport master (input cols, output rows, pad, multi_press, new_press);
  modport slave (output cols, input rows, pad, multi_press, new_press);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce that commits a one-hot pad after enough identical frames
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                frame_done,
  input  logic [NUM_KEYS-1:0] snapshot,
  output logic [NUM_KEYS-1:0] pad,
  output logic                multi_press,
  output logic                new_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEBOUNCE_FRAMES);
  logic [NUM_KEYS-1:0] last_snapshot, next_pad;
  logic [CNT_W-1:0] stable_cnt, next_cnt;
  logic [4:0] ones;
  logic commit;
  // Run length of identical frames saturates at FULL, so commits repeat on every stable frame
  always_comb begin
    ones = popcount16(snapshot);
    next_cnt = snapshot != last_snapshot ? CNT_W'(1) : stable_cnt == FULL ? FULL : stable_cnt + 1'b1;
    commit = frame_done && next_cnt == FULL;
    next_pad = ones == 5'd1 ? snapshot : '0;
  end
  // Track the previous frame and publish committed key state; pulse only on a new nonzero key
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      last_snapshot <= '0;
      stable_cnt <= '0;
      pad <= '0;
      multi_press <= 1'b0;
      new_press <= 1'b0;
    end else begin
      new_press <= commit && next_pad != pad && next_pad != '0;
      if (frame_done) begin
        last_snapshot <= snapshot;
        stable_cnt <= next_cnt;
      end
      if (commit) begin
        pad <= next_pad;
        multi_press <= ones >= 5'd2;
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scans a 4x4 active-low keypad and reports a debounced one-hot key
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  keypad_scanner_if.master kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  logic [NUM_COLS-1:0] sync_a, cols_s;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0] row_idx;
  logic [11:0] raw;
  logic [NUM_KEYS-1:0] snapshot;
  logic sample, frame_done;
  // Rows 0..2 are shifted into raw in scan order; row 3 is merged straight from the synchroniser
  always_comb begin
    sample = div_cnt == DIV_LAST;
    frame_done = sample && row_idx == 2'd3;
    snapshot = {~cols_s, raw};
  end
  // Synchronise column returns, run the dwell counter and advance the row drive on each sample
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_a <= '1;
      cols_s <= '1;
      div_cnt <= '0;
      row_idx <= '0;
      raw <= '0;
      kp.rows <= 4'b1110;
    end else begin
      sync_a <= kp.cols;
      cols_s <= sync_a;
      div_cnt <= sample ? '0 : div_cnt + 1'b1;
      if (sample) begin
        raw <= {~cols_s, raw[11:4]};
        row_idx <= row_idx + 2'd1;
        kp.rows <= ~(4'b0001 << (row_idx + 2'd1));
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .frame_done(frame_done),
    .snapshot(snapshot),
    .pad(kp.pad),
    .multi_press(kp.multi_press),
    .new_press(kp.new_press)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized frame stimulus against a frame-level reference model with a scoreboard
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int D = 2;
  localparam int FRAME = 4 * SD;
  typedef struct packed {
    int          cyc;
    logic [15:0] pad;
    logic        multi;
    logic        np;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys = '0;
  int cyc = 0;
  int t0 = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit rows_ok = 1'b0;
  logic [15:0] hist[$];
  ev_t exp_q[$];
  logic [15:0] m_pad = '0;
  logic m_multi = 1'b0;
  keypad_scanner_if kp();
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(D)) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .kp(kp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Keypad matrix: a closed key pulls its column low while its row is driven low
  always_comb begin
    kp.cols = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.rows[r] && keys[r*4+c]) kp.cols[c] = 1'b0;
  end
  // Hold a key set for one full frame, then let the model decide whether that frame commits
  task automatic apply_frame(input logic [15:0] k);
    bit same;
    logic [15:0] np;
    logic nm;
    keys = k;
    repeat (FRAME) @(posedge clk);
    #1;
    hist.push_back(k);
    same = hist.size() >= D;
    for (int i = 1; i < D; i++)
      if (same && hist[hist.size()-1-i] != k) same = 1'b0;
    if (same) begin
      np = $countones(k) == 1 ? k : 16'h0;
      nm = $countones(k) >= 2;
      if (np != m_pad || nm != m_multi)
        exp_q.push_back(ev_t'{cyc, np, nm, np != m_pad && np != 16'h0});
      m_pad = np;
      m_multi = nm;
    end
  endtask
  task automatic do_reset(input int n);
    rows_ok = 1'b0;
    reset = 1'b1;
    if (m_pad != 16'h0 || m_multi) exp_q.push_back(ev_t'{cyc + 1, 16'h0, 1'b0, 1'b0});
    m_pad = '0;
    m_multi = 1'b0;
    hist.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
    rows_ok = 1'b1;
  endtask
  // Monitor: check the row drive every cycle and pop an expectation whenever the outputs move
  initial begin
    logic [15:0] pp;
    logic pm;
    logic [3:0] er;
    ev_t e;
    @(posedge clk);
    @(negedge clk);
    pp = kp.pad;
    pm = kp.multi_press;
    forever begin
      @(negedge clk);
      if (rows_ok) begin
        n_vec++;
        er = ~(4'b0001 << (((cyc - t0) / SD) % 4));
        if (kp.rows !== er) begin
          n_bad++;
          $display("FAIL rows cyc=%0d got=%b exp=%b", cyc - t0, kp.rows, er);
        end
      end
      if (kp.pad !== pp || kp.multi_press !== pm || kp.new_press !== 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d got pad=%h multi=%b new=%b exp none", cyc, kp.pad, kp.multi_press, kp.new_press);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.pad !== kp.pad || e.multi !== kp.multi_press || e.np !== kp.new_press) begin
            n_bad++;
            $display("FAIL event got cyc=%0d pad=%h multi=%b new=%b exp cyc=%0d pad=%h multi=%b new=%b",
                     cyc, kp.pad, kp.multi_press, kp.new_press, e.cyc, e.pad, e.multi, e.np);
          end
        end
      end
      pp = kp.pad;
      pm = kp.multi_press;
    end
  end
  // Stimulus: directed scenarios first, then random frames
  initial begin
    logic [15:0] k;
    do_reset(3);
    repeat (13) apply_frame(16'h0);
    keys = 16'h0020;
    do_reset(2);
    repeat (3) apply_frame(16'h0020);
    repeat (3) apply_frame(16'h0);
    apply_frame(16'h0020);
    apply_frame(16'h0);
    repeat (3) apply_frame(16'h0020);
    repeat (2) apply_frame(16'h0);
    repeat (3) apply_frame(16'h0204);
    repeat (3) apply_frame(16'h0004);
    repeat (3) apply_frame(16'h0800);
    repeat (3) apply_frame(16'h0);
    repeat (3) apply_frame(16'h0800);
    repeat (3) apply_frame(16'h0008);
    repeat (9) @(posedge clk);
    #1;
    do_reset(1);
    repeat (3) apply_frame(16'h0008);
    k = 16'h0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        3: k = 16'h0001 << $urandom_range(0, 15);
        4: k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        5: k = $urandom_range(0, 1) ? 16'h0 : 16'($urandom);
        default: k = k;
      endcase
      apply_frame(k);
    end
    repeat (3) apply_frame(16'h0);
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage that drives and reads the 4x4 matrix keypad on the GPIO header.
- Scans rows one at a time, synchronises and debounces the column returns, and publishes a one-hot 16-bit pad vector.
- Its output feeds the scorer comparison against curr_note and the tone player.
- Only one clean key is ever reported: a pad value is either zero or exactly one bit set.

Parameters:
- SCAN_DIV, 50000, CLOCK_50 cycles per row dwell (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-matrix frames required before a new pad value commits; must be >= 1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- cols  in  4  keypad column returns; active-low (pulled up, low = key closed on the driven row); asynchronous.
- rows  out  4  row drive; active-low, exactly one bit low at all times.
- pad  out  16  debounced one-hot key, index = row*4 + col; zero when no key or more than one key is pressed.
- multi_press  out  1  high while the committed frame has 2 or more keys closed.
- new_press  out  1  one-cycle pulse when pad commits to a nonzero value different from its previous value.

Behaviour:
- Single clock domain, CLOCK_50. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - rows = 4'b1110 (row 0 driven); pad = 0; multi_press = 0; new_press = 0.
  - div_cnt = 0; row_idx = 0; raw frame = 0; last_snapshot = 0; stable_cnt = 0.
  - Both synchroniser stages = 4'b1111.
- Reset asserted mid-scan: all state returns to the reset values on the next edge. No partial frame is kept.
- Synchroniser: cols passes through a 2-flop synchroniser to give cols_s. Closed = ~cols_s.
- Dwell counter:
  - div_cnt counts 0 .. SCAN_DIV-1, then wraps to 0.
  - The sample cycle is the cycle where div_cnt == SCAN_DIV-1.
  - On the sample cycle: raw[row_idx*4 +: 4] <= ~cols_s; row_idx <= row_idx+1 (wraps 3 -> 0); rows <= ~(1 << next row_idx).
  - Settling time after a row change is SCAN_DIV-1 cycles, which covers the 2-cycle synchroniser latency.
- Frame done: the sample cycle with row_idx == 3.
  - snapshot = raw with the row-3 sample merged in combinationally.
  - If snapshot == last_snapshot: stable_cnt <= min(stable_cnt+1, DEBOUNCE_FRAMES).
  - Else: stable_cnt <= 1.
  - In both cases: last_snapshot <= snapshot.
- Commit: on a frame-done cycle where the new stable_cnt value equals DEBOUNCE_FRAMES, on the next edge:
  - pad <= (popcount(snapshot) == 1) ? snapshot : 0.
  - multi_press <= (popcount(snapshot) >= 2).
  - Commits repeat on every later stable frame; pad holds its value between commits.
- new_press:
  - Asserted for exactly the one cycle in which pad takes its new value.
  - Condition: new pad != old pad and new pad != 0.
  - Release (pad -> 0) gives no pulse. A direct key-to-key change (A -> B with no gap) does pulse.
- Latency (single key closed and held, matrix previously idle, DEBOUNCE_FRAMES = D): pad updates within (D+1) frames + 1 cycle, where a frame is 4*SCAN_DIV cycles.
- Bounce: any frame that differs from the previous frame restarts the count at 1. pad never glitches on bounce shorter than D-1 full frames.
- Counter widths: div_cnt is $clog2(SCAN_DIV) bits; stable_cnt is $clog2(DEBOUNCE_FRAMES+1) bits. No overflow is possible because stable_cnt saturates.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS = 4, NUM_COLS = 4, NUM_KEYS = 16.
  - The key-index convention (row*4 + col).
  - A popcount16 function.
- One sub-module, keypad_debounce, contains last_snapshot, stable_cnt, commit logic, the pad / multi_press / new_press registers and the popcount. Its inputs are CLOCK_50, reset, frame_done and snapshot.
- The scan counter, row drive and synchroniser stay in keypad_scanner.

Test Plan (SCAN_DIV = 4, DEBOUNCE_FRAMES = 2, frame = 16 cycles; the bench models the matrix by pulling cols[c] low while rows[r] is low and key r*4+c is closed):
- Idle after reset -> rows cycles 1110, 1101, 1011, 0111, each held 4 cycles. pad = 0, multi_press = 0 and new_press = 0 for 200 cycles.
- Key 5 (row 1, col 1) closed before reset release and held -> pad = 16'h0020 from cycle 32 onward. new_press is high at cycle 32 only.
- Key 5 bounces open for 1 frame after 1 stable frame, then stays closed -> no commit until 2 consecutive identical frames. pad stays 0 through the bounce, then 16'h0020 with one pulse.
- Keys 2 and 9 held together -> after debounce, pad = 0 and multi_press = 1. Releasing key 9 -> pad = 16'h0004 with one new_press pulse, and multi_press = 0.
- Key 11 held then released -> pad = 16'h0800, then 0 after 2 idle frames, with no pulse on release. Pressing key 11 again -> a fresh pulse.
- reset asserted for 1 cycle mid-row-2 dwell while key 3 is committed -> the next cycle shows rows = 1110, pad = 0 and new_press = 0. Key 3 still held -> it recommits 32 cycles after reset release.
